pipelined_adder: RTL and testbench

//  Parametrised N-bit add/subtract unit, successor to the 4-bit combinational adder.

---
 rtl/pipelined_adder.sv | 160 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract unit with the carry chain cut into
// CHUNK-bit slices, one register stage per slice, and valid/ready
// handshakes on both sides. One operation per cycle at full throughput;
// latency is STAGES cycles from the accepting edge.
//
// The arithmetic is {co,sum} = a + (b ^ {WIDTH{sub}}) + (ci ^ sub), so
// sub=1 with ci=0 gives a - b, and co=1 then means "no borrow".
// ovf is the signed overflow of that same addition.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   operand tuple valid
//   in_ready_o   unit accepts a tuple this cycle
//   a_i, b_i     operands (WIDTH bits, unsigned or two's complement)
//   ci_i         carry in
//   sub_i        1 = subtract, 0 = add
//   out_valid_o  result valid
//   out_ready_i  consumer takes the result this cycle
//   sum_o        result (WIDTH bits)
//   co_o         carry out of the MSB
//   ovf_o        signed overflow
//
// WIDTH must be a multiple of CHUNK; CHUNK == WIDTH gives a single stage.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic             ovf_o
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Subtract handling is folded into the operands once, at the input.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ovf_q;

  assign b_eff = b_i ^ {WIDTH{sub_i}};
  assign c_eff = ci_i ^ sub_i;

  for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
    // DW: result bits finished once this stage has been loaded.
    // PW: operand bits still to be summed by later stages.
    localparam int DW = (gi + 1) * CHUNK;
    localparam int PW = WIDTH - DW;

    logic             valid_q;
    logic             carry_q;
    logic             en;       // this stage's register may load this cycle
    logic             v_in;
    logic             c_in;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_sum;
    logic [DW-1:0]    res_d;
    logic [DW-1:0]    res_q;

    if (gi == 0) begin : gen_src
      assign v_in  = in_valid_i;
      assign c_in  = c_eff;
      assign a_sl  = a_i[CHUNK-1:0];
      assign b_sl  = b_eff[CHUNK-1:0];
      assign res_d = slice_sum[CHUNK-1:0];
    end else begin : gen_fwd
      // The lowest pending bits of the previous stage are this stage's slice.
      assign v_in  = gen_stage[gi-1].valid_q;
      assign c_in  = gen_stage[gi-1].carry_q;
      assign a_sl  = gen_stage[gi-1].gen_pend.a_hi_q[CHUNK-1:0];
      assign b_sl  = gen_stage[gi-1].gen_pend.b_hi_q[CHUNK-1:0];
      assign res_d = {slice_sum[CHUNK-1:0], gen_stage[gi-1].res_q};
    end

    assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_in};

    // A stage can load when it is empty or its contents move on this cycle,
    // so bubbles collapse even while the output is stalled.
    if (gi == LAST) begin : gen_en_last
      assign en = !valid_q || out_ready_i;
    end else begin : gen_en_mid
      assign en = !valid_q || gen_stage[gi+1].en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (en) begin
        valid_q <= v_in;
        if (v_in) begin
          carry_q <= slice_sum[CHUNK];
          res_q   <= res_d;
        end
      end
    end

    // Operand bits not yet summed travel with the tuple.
    if (gi < LAST) begin : gen_pend
      logic [PW-1:0] a_hi_d;
      logic [PW-1:0] b_hi_d;
      logic [PW-1:0] a_hi_q;
      logic [PW-1:0] b_hi_q;

      if (gi == 0) begin : gen_cut
        assign a_hi_d = a_i[WIDTH-1:CHUNK];
        assign b_hi_d = b_eff[WIDTH-1:CHUNK];
      end else begin : gen_shift
        assign a_hi_d = gen_stage[gi-1].gen_pend.a_hi_q[PW+CHUNK-1:CHUNK];
        assign b_hi_d = gen_stage[gi-1].gen_pend.b_hi_q[PW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (en && v_in) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end
    end

    // The last stage sees the operand sign bits and the result sign bit,
    // so overflow is resolved and registered alongside the final slice.
    if (gi == LAST) begin : gen_ovf
      logic ovf_d;

      assign ovf_d = (a_sl[CHUNK-1] == b_sl[CHUNK-1]) &&
                     (slice_sum[CHUNK-1] != a_sl[CHUNK-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en && v_in) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign in_ready_o  = gen_stage[0].en;
  assign out_valid_o = gen_stage[LAST].valid_q;
  assign sum_o       = gen_stage[LAST].res_q;
  assign co_o        = gen_stage[LAST].carry_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder: a 4-stage build (WIDTH=16, CHUNK=4) and a
// single-stage build (CHUNK=WIDTH) share one stimulus stream. Each unit has
// its own scoreboard queue filled when it accepts a tuple and drained by a
// monitor whenever it hands a result to the consumer.
module tb_pipelined_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         in_ready, out_valid, co, ovf;
  logic [W-1:0] sum;
  logic         in_ready1, out_valid1, co1, ovf1;
  logic [W-1:0] sum1;

  int total = 0;
  int bad = 0;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  bit          use_exp = 1'b0;
  logic [17:0] exp_val = '0;
  int          run_len = 0;
  int          max_run = 0;
  bit          rand_or = 1'b0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .ci_i(ci), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .co_o(co), .ovf_o(ovf)
  );

  pipelined_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .a_i(a), .b_i(b), .ci_i(ci), .sub_i(sub),
    .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .sum_o(sum1), .co_o(co1), .ovf_o(ovf1)
  );

  // Reference: plain integer arithmetic; result packed as {co, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [15:0] ye;
    int          full;
    int          sgn;
    logic        v;
    ye   = s ? ~y : y;
    full = int'(x) + int'(ye) + int'(c ^ s);
    sgn  = int'($signed(x)) + int'($signed(ye)) + int'(c ^ s);
    v    = (sgn > 32767) || (sgn < -32768);
    return {full[16], v, full[15:0]};
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      run_len = 0;
    end else begin
      if (in_valid && in_ready) q0.push_back(use_exp ? exp_val : model(a, b, ci, sub));
      if (in_valid && in_ready1) q1.push_back(model(a, b, ci, sub));
      if (out_valid && out_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        $display("dut0 result sum=%h co=%b ovf=%b", sum, co, ovf);
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut0_spurious: got sum=%h with no tuple outstanding", sum);
        end else begin
          check("dut0_result", {14'b0, co, ovf, sum}, {14'b0, q0.pop_front()});
        end
      end else begin
        run_len = 0;
      end
      if (out_valid1 && out_ready) begin
        $display("dut1 result sum=%h co=%b ovf=%b", sum1, co1, ovf1);
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut1_spurious: got sum=%h with no tuple outstanding", sum1);
        end else begin
          check("dut1_result", {14'b0, co1, ovf1, sum1}, {14'b0, q1.pop_front()});
        end
      end
    end
  end

  // Random consumer backpressure during the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Present a tuple and hold it until the 4-stage unit accepts it.
  // Starts and returns one time unit after a rising edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                      input logic s, input bit ue, input logic [17:0] ev);
    int n = 0;
    a = x; b = y; ci = c; sub = s; use_exp = ue; exp_val = ev;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    use_exp  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [17:0] first;

    // Reset state.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_co", co, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);

    // Add wrap with latency measurement on an empty pipe.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("latency_cycles", n, 4);
    @(posedge clk);
    #1;

    // Directed arithmetic corners, back to back.
    send(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h1000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h8000});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    idle(8);

    // Stream of 8 back-to-back tuples.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 3), 1'b0, 1'b0, 1'b0, '0);
    idle(8);
    check("stream_run", max_run, 8);

    // Backpressure: fill the pipe with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h1234 + 16'(i), 16'h0F0F, 1'b1, 1'(i & 1), 1'b0, '0);
    first = model(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    a = 16'hA5A5; b = 16'h5A5A; ci = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum_held", sum, first[15:0]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1'b0, '0);
    idle(8);

    // Reset with tuples in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h0100 * 16'(i + 1), 16'h0011, 1'b0, 1'b0, 1'b0, '0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_out_valid1", out_valid1, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", in_ready, 1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || out_valid1) n++;
    end
    check("midrst_no_stale", n, 0);
    @(posedge clk);
    #1;

    // Random add/sub with random gaps and random consumer stalls.
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        idle(1);
      end else begin
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
      end
    end
    in_valid = 1'b0;
    rand_or = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
